// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writes win, late-unit results queue in a FIFO.
// Optional same-cycle bypass of an empty FIFO is enabled by defining WBARB_BYPASS_EN.
module wb_port_arbiter #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int AGE_MAX = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     RegWriteW,
  input  logic [4:0]               RdW,
  input  logic [WIDTH-1:0]         ResultW,
  input  logic                     lu_valid,
  output logic                     lu_ready,
  input  logic [4:0]               lu_rd,
  input  logic [WIDTH-1:0]         lu_data,
  output logic                     rf_we,
  output logic [4:0]               rf_waddr,
  output logic [WIDTH-1:0]         rf_wdata,
  output logic [31:0]              pend_mask,
  output logic [$clog2(DEPTH):0]   pend_cnt,
  output logic                     bubble_req
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = $clog2(AGE_MAX + 1);

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_live;
  logic [4:0]       ent_rd   [DEPTH];
  logic [WIDTH-1:0] ent_data [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic [CW-1:0]    count;
  logic [AW-1:0]    age;

  logic             pipe_wr;
  logic             head_valid, head_live, head_writable;
  logic [4:0]       head_rd;
  logic [WIDTH-1:0] head_data;
  logic             pop, accept, bypass, enq_live;

  assign pipe_wr       = RegWriteW && (RdW != 5'd0);
  assign head_valid    = (count != '0);
  assign head_live     = ent_live[rptr];
  assign head_rd       = ent_rd[rptr];
  assign head_data     = ent_data[rptr];
  assign head_writable = head_valid && head_live && (head_rd != 5'd0);

  // Dead heads (killed or x0) retire even while the pipeline owns the port.
  assign pop      = head_valid && (!head_live || (head_rd == 5'd0) || !pipe_wr);
  assign lu_ready = (count < CW'(DEPTH));
  assign pend_cnt = count;

`ifdef WBARB_BYPASS_EN
  assign bypass = (count == '0) && !pipe_wr && lu_valid;
`else
  assign bypass = 1'b0;
`endif

  assign accept   = lu_valid && lu_ready && !bypass;
  assign enq_live = !(pipe_wr && (lu_rd == RdW));

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = '0;
    if (rst_n) begin
      if (pipe_wr) begin
        rf_we    = 1'b1;
        rf_waddr = RdW;
        rf_wdata = ResultW;
      end else if (bypass) begin
        rf_we    = 1'b1;
        rf_waddr = lu_rd;
        rf_wdata = lu_data;
      end else if (head_writable) begin
        rf_we    = 1'b1;
        rf_waddr = head_rd;
        rf_wdata = head_data;
      end
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && ent_live[i] && (ent_rd[i] != 5'd0))
        pend_mask[ent_rd[i]] = 1'b1;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by ent_valid/count.
  always_ff @(posedge clk) begin
    if (accept) begin
      ent_rd[wptr]   <= lu_rd;
      ent_data[wptr] <= lu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid  <= '0;
      ent_live   <= '0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      age        <= '0;
      bubble_req <= 1'b0;
    end else begin
      if (pipe_wr) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (ent_rd[i] == RdW)
            ent_live[i] <= 1'b0;
        end
      end
      if (pop) begin
        ent_valid[rptr] <= 1'b0;
        rptr            <= rptr + PW'(1);
      end
      // The enqueue slot is written last so its live bit already accounts for a same-cycle kill.
      if (accept) begin
        ent_valid[wptr] <= 1'b1;
        ent_live[wptr]  <= enq_live;
        wptr            <= wptr + PW'(1);
      end
      unique case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (pop)
        age <= '0;
      else if (head_writable && pipe_wr && (age != AW'(AGE_MAX)))
        age <= age + AW'(1);
      bubble_req <= !pop && (age == AW'(AGE_MAX));
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed scoreboard bench for wb_port_arbiter: stimulus pushes the per-cycle expected
// write-port value, a negedge monitor pops and compares it against rf_we/rf_waddr/rf_wdata.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pend_mask;
  logic [2:0]  pend_cnt;
  logic        bubble_req;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  wb_port_arbiter #(.WIDTH(32), .DEPTH(4), .AGE_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pend_mask(pend_mask), .pend_cnt(pend_cnt), .bubble_req(bubble_req)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checkOutput("rf_we", 64'(rf_we), 64'(e.we));
      if (e.we) begin
        checkOutput("rf_waddr", 64'(rf_waddr), 64'(e.addr));
        checkOutput("rf_wdata", 64'(rf_wdata), 64'(e.data));
      end
    end
  end

  // Called just after a posedge; drives one cycle of inputs and returns just after the next posedge.
  task automatic applyStimulus(input logic rw, input logic [4:0] rd, input logic [31:0] res,
                               input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                               input logic ewe, input logic [4:0] eaddr, input logic [31:0] edata);
    exp_t e;
    RegWriteW = rw;
    RdW       = rd;
    ResultW   = res;
    lu_valid  = lv;
    lu_rd     = lrd;
    lu_data   = ldat;
    e.we = ewe; e.addr = eaddr; e.data = edata;
    exp_q.push_back(e);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ewe, input logic [4:0] eaddr, input logic [31:0] edata);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, ewe, eaddr, edata);
  endtask

  initial begin
    rst_n = 1'b0;
    RegWriteW = 1'b0; RdW = '0; ResultW = '0;
    lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
    repeat (2) @(posedge clk);
    #1;

    // Outputs held quiet in reset even with a pipeline write offered
    RegWriteW = 1'b1; RdW = 5'd4; ResultW = 32'h44;
    #1;
    checkOutput("reset_rf_we", 64'(rf_we), 64'd0);
    checkOutput("reset_rf_waddr", 64'(rf_waddr), 64'd0);
    checkOutput("reset_rf_wdata", 64'(rf_wdata), 64'd0);
    checkOutput("reset_lu_ready", 64'(lu_ready), 64'd1);
    checkOutput("reset_pend_cnt", 64'(pend_cnt), 64'd0);
    checkOutput("reset_pend_mask", 64'(pend_mask), 64'd0);
    checkOutput("reset_bubble", 64'(bubble_req), 64'd0);
    applyStimulus(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    rst_n = 1'b1;

    // Single late result on an idle port
`ifdef WBARB_BYPASS_EN
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEAD, 1'b1, 5'd5, 32'hDEAD);
    checkOutput("byp_pend_cnt", 64'(pend_cnt), 64'd0);
    checkOutput("byp_pend_mask", 64'(pend_mask), 64'd0);
    idle(1'b0, 5'd0, 32'h0);
`else
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEAD, 1'b0, 5'd0, 32'h0);
    checkOutput("t1_pend_cnt", 64'(pend_cnt), 64'd1);
    checkOutput("t1_pend_mask", 64'(pend_mask), 64'h20);
    idle(1'b1, 5'd5, 32'hDEAD);
`endif
    checkOutput("t1_pend_cnt_after", 64'(pend_cnt), 64'd0);
    checkOutput("t1_pend_mask_after", 64'(pend_mask), 64'd0);

    // Fill to DEPTH behind pipeline writes, then drain in order
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 5'd20, 32'h100 + i, 1'b1, 5'(i), 32'h10 * i, 1'b1, 5'd20, 32'h100 + i);
      checkOutput("fill_pend_cnt", 64'(pend_cnt), 64'(i));
      checkOutput("fill_lu_ready", 64'(lu_ready), (i == 4) ? 64'd0 : 64'd1);
    end
    applyStimulus(1'b1, 5'd20, 32'h205, 1'b1, 5'd5, 32'h555, 1'b1, 5'd20, 32'h205);
    checkOutput("full_pend_cnt", 64'(pend_cnt), 64'd4);
    checkOutput("full_pend_mask", 64'(pend_mask), 64'h1E);
    idle(1'b1, 5'd1, 32'h10);
    checkOutput("drain_pend_cnt1", 64'(pend_cnt), 64'd3);
    checkOutput("drain_lu_ready", 64'(lu_ready), 64'd1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h66, 1'b1, 5'd2, 32'h20);
    checkOutput("enq_pop_pend_cnt", 64'(pend_cnt), 64'd3);
    idle(1'b1, 5'd3, 32'h30);
    idle(1'b1, 5'd4, 32'h40);
    idle(1'b1, 5'd6, 32'h66);
    checkOutput("drained_pend_cnt", 64'(pend_cnt), 64'd0);
    checkOutput("drained_pend_mask", 64'(pend_mask), 64'd0);

    // WAW kill by a later pipeline write
    applyStimulus(1'b1, 5'd20, 32'h300, 1'b1, 5'd7, 32'h77, 1'b1, 5'd20, 32'h300);
    checkOutput("kill_mask_before", 64'(pend_mask), 64'h80);
    applyStimulus(1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h11);
    checkOutput("kill_mask_after", 64'(pend_mask), 64'd0);
    checkOutput("kill_pend_cnt", 64'(pend_cnt), 64'd1);
    idle(1'b0, 5'd0, 32'h0);
    checkOutput("kill_popped_cnt", 64'(pend_cnt), 64'd0);

    // Same-cycle enqueue and kill; dead head retires under a pipeline write
    applyStimulus(1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 32'hBAD, 1'b1, 5'd9, 32'h99);
    checkOutput("samekill_cnt", 64'(pend_cnt), 64'd1);
    checkOutput("samekill_mask", 64'(pend_mask), 64'd0);
    applyStimulus(1'b1, 5'd21, 32'h21, 1'b0, 5'd0, 32'h0, 1'b1, 5'd21, 32'h21);
    checkOutput("samekill_popped_cnt", 64'(pend_cnt), 64'd0);

    // Starved head raises bubble_req after AGE_MAX blocked cycles
    applyStimulus(1'b1, 5'd9, 32'h900, 1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'h900);
    checkOutput("age_mask", 64'(pend_mask), 64'h8);
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b1, 5'd9, 32'h900 + k, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h900 + k);
      if (k == 8) checkOutput("bubble_at_8", 64'(bubble_req), 64'd0);
      if (k == 9) checkOutput("bubble_at_9", 64'(bubble_req), 64'd1);
      if (k == 10) checkOutput("bubble_at_10", 64'(bubble_req), 64'd1);
    end
    idle(1'b1, 5'd3, 32'h33);
    checkOutput("bubble_cleared", 64'(bubble_req), 64'd0);
    checkOutput("age_pend_cnt", 64'(pend_cnt), 64'd0);

    // Reset in the middle of a drain discards queued results
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 5'd20, 32'h400 + i, 1'b1, 5'(10 + i), 32'hA0 + i, 1'b1, 5'd20, 32'h400 + i);
    checkOutput("mid_pend_cnt", 64'(pend_cnt), 64'd3);
    checkOutput("mid_pend_mask", 64'(pend_mask), 64'h1C00);
    idle(1'b1, 5'd10, 32'hA0);
    checkOutput("mid_pend_cnt2", 64'(pend_cnt), 64'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_cnt", 64'(pend_cnt), 64'd0);
    checkOutput("mid_rst_mask", 64'(pend_mask), 64'd0);
    checkOutput("mid_rst_we", 64'(rf_we), 64'd0);
    idle(1'b0, 5'd0, 32'h0);
    rst_n = 1'b1;
    idle(1'b0, 5'd0, 32'h0);
    idle(1'b0, 5'd0, 32'h0);
    checkOutput("post_rst_cnt", 64'(pend_cnt), 64'd0);

    @(negedge clk);
    checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
